// File: rtl/data_mem_pkg.sv
// Shared definitions for the byte-addressed data memory port.
// Size encodings, response error codes and small helpers.
package data_mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } mem_size_e;

   localparam logic        RESP_OK    = 1'b0;
   localparam logic        RESP_ERR   = 1'b1;
   localparam logic [31:0] RDATA_NONE = 32'd0;

   // Number of bytes touched by an access of the given size (0 for reserved).
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         SZ_WORD: size_bytes = 3'd4;
         default: size_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/latency_pipe.sv
// Fixed-depth response delay line: shifts valid/data/err through LATENCY
// stages. A synchronous active-low reset flushes every stage.
module latency_pipe #(
   parameter int LATENCY = 10,
   parameter int W       = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         in_err,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_err
);

   logic [LATENCY-1:0] valid_reg;
   logic [LATENCY-1:0] err_reg;
   logic [W-1:0]       data_reg [LATENCY];

   genvar gi;
   generate
      for (gi = 0; gi < LATENCY; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            // First stage captures the response formed at the accept edge.
            always_ff @(posedge clk) begin
               if (!rstn) begin
                  valid_reg[0] <= 1'b0;
                  err_reg[0]   <= 1'b0;
                  data_reg[0]  <= '0;
               end else begin
                  valid_reg[0] <= in_valid;
                  err_reg[0]   <= in_err;
                  data_reg[0]  <= in_data;
               end
            end
         end else begin : g_tail
            // Later stages simply shift the previous stage forward.
            always_ff @(posedge clk) begin
               if (!rstn) begin
                  valid_reg[gi] <= 1'b0;
                  err_reg[gi]   <= 1'b0;
                  data_reg[gi]  <= '0;
               end else begin
                  valid_reg[gi] <= valid_reg[gi-1];
                  err_reg[gi]   <= err_reg[gi-1];
                  data_reg[gi]  <= data_reg[gi-1];
               end
            end
         end
      end
   endgenerate

   // Data and error are forced quiet outside the response pulse.
   assign out_valid = valid_reg[LATENCY-1];
   assign out_err   = valid_reg[LATENCY-1] & err_reg[LATENCY-1];
   assign out_data  = valid_reg[LATENCY-1] ? data_reg[LATENCY-1] : '0;

endmodule

// File: rtl/data_mem_port.sv
// Big-endian byte-addressed data memory with a single outstanding request
// and a fixed LATENCY response. Accesses run at the accept edge; the
// response is delayed through latency_pipe.
// Optional build macro DATA_MEM_PORT_ALIGN_CHECK_EN rejects misaligned
// half/word accesses; without it misaligned accesses are performed.
module data_mem_port
   import data_mem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 10,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [7:0]        mem [DEPTH];
   logic              busy_reg;
   logic              accept;
   logic [2:0]        nbytes;
   logic [ADDR_W:0]   last_addr;
   logic              size_err;
   logic              range_err;
   logic              align_err;
   logic              req_err;
   logic              access_ok;
   logic [IDX_W-1:0]  idx [4];
   logic [7:0]        rd_byte [4];
   logic [7:0]        wr_byte [4];
   logic [3:0]        wr_en;
   logic [31:0]       wdata_left;
   logic [31:0]       load_data;
   logic [31:0]       pipe_data;

   // Idle again in the response cycle so a new request can be taken then.
   assign req_ready = ~busy_reg | resp_valid;
   assign accept    = req_valid & req_ready;

   // Request checks: reserved size, end of access past the array, alignment.
   assign nbytes    = size_bytes(req_size);
   assign last_addr = {1'b0, req_addr} + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
   assign size_err  = (req_size == SZ_RSVD);
   assign range_err = (last_addr >= (ADDR_W+1)'(DEPTH));
`ifdef DATA_MEM_PORT_ALIGN_CHECK_EN
   assign align_err = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
   assign align_err = 1'b0;
`endif
   assign req_err   = size_err | range_err | align_err;
   assign access_ok = accept & ~req_err;

   // Byte lane k addresses a+k; lane 0 is the most significant byte.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign idx[gi]     = req_addr[IDX_W-1:0] + IDX_W'(gi);
         assign rd_byte[gi] = mem[idx[gi]];
         assign wr_byte[gi] = wdata_left[31-8*gi -: 8];
         assign wr_en[gi]   = access_ok & req_write & (3'(gi) < nbytes);
      end
   endgenerate

   // Left-justify store data and assemble/extend load data by size.
   always_comb begin
      wdata_left = req_wdata;
      load_data  = RDATA_NONE;
      case (req_size)
         SZ_BYTE: begin
            wdata_left = {req_wdata[7:0], 24'd0};
            load_data  = {{24{~req_unsigned & rd_byte[0][7]}}, rd_byte[0]};
         end
         SZ_HALF: begin
            wdata_left = {req_wdata[15:0], 16'd0};
            load_data  = {{16{~req_unsigned & rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
         end
         SZ_WORD: begin
            load_data  = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
         end
         default: begin
            load_data  = RDATA_NONE;
         end
      endcase
   end

   assign pipe_data = (access_ok & ~req_write) ? load_data : RDATA_NONE;

   // Byte storage: cleared by reset, stores commit at the accept edge.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 8'd0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
               mem[idx[k]] <= wr_byte[k];
            end
         end
      end
   end

   // Outstanding-request flag: set on accept, cleared when the response leaves.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         busy_reg <= 1'b0;
      end else if (accept) begin
         busy_reg <= 1'b1;
      end else if (resp_valid) begin
         busy_reg <= 1'b0;
      end
   end

   latency_pipe #(
      .LATENCY (LATENCY),
      .W       (32)
   ) u_latency_pipe (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (accept),
      .in_data   (pipe_data),
      .in_err    (accept & req_err ? RESP_ERR : RESP_OK),
      .out_valid (resp_valid),
      .out_data  (resp_rdata),
      .out_err   (resp_err)
   );

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: stores/loads, sign extension,
// range and size errors, misaligned access, back-to-back accepts and
// reset with a request in flight.
module tb_data_mem_port;

   localparam int DEPTH = 1024;
   localparam int LAT   = 10;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;

   int checks = 0;
   int errors = 0;

   data_mem_port #(
      .DEPTH   (DEPTH),
      .LATENCY (LAT),
      .ADDR_W  (AW)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the port idle; returns just after the accept edge.
   task automatic send(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      req_valid    = 1'b1;
      @(posedge clk);
      #1;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_size     = 2'b00;
      req_addr     = '0;
      req_wdata    = '0;
   endtask

   // Waits (bounded) for the response; ends at the negedge of the response cycle.
   task automatic wait_resp(input string tag, output logic [31:0] rd, output logic er);
      int n;
      int busy_bad;
      n = 0;
      busy_bad = 0;
      rd = 32'hX;
      er = 1'bX;
      for (int i = 1; i <= LAT + 4; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            n  = i;
            rd = resp_rdata;
            er = resp_err;
            break;
         end
         if (req_ready !== 1'b0) busy_bad++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(LAT));
      chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
   endtask

   task automatic txn(input string tag, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_er);
      logic [31:0] rd;
      logic        er;
      send(wr, sz, uns, addr, wd);
      wait_resp(tag, rd, er);
      chk({tag, "_rdata"}, rd, exp_rd);
      chk({tag, "_err"}, 32'(er), 32'(exp_er));
      $display("txn %s wr=%0b size=%0d addr=%h rdata=%h err=%0b", tag, wr, sz, addr, rd, er);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      int vcount;
      logic [31:0] rd;
      logic        er;

      rstn = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_size = 2'b00;
      req_unsigned = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      rstn = 1'b1;

      // First request in the very first cycle after reset release.
      txn("st_word_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
      txn("ld_word_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
      @(negedge clk);
      chk("idle_resp_valid", 32'(resp_valid), 32'd0);
      chk("idle_resp_rdata", resp_rdata, 32'd0);

      // Sign/zero extension.
      txn("st_byte_20", 1'b1, 2'b00, 1'b0, 32'h20, 32'h00000080, 32'h0, 1'b0);
      txn("ld_byte_s", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0);
      txn("ld_byte_u", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'h00000080, 1'b0);
      txn("st_half_30", 1'b1, 2'b01, 1'b0, 32'h30, 32'hFFFF8001, 32'h0, 1'b0);
      txn("ld_half_s", 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 32'hFFFF8001, 1'b0);
      txn("ld_half_u", 1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 32'h00008001, 1'b0);
      txn("ld_byte_31", 1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 32'h00000001, 1'b0);

      // End-of-memory boundary, range and reserved-size errors.
      txn("st_byte_top", 1'b1, 2'b00, 1'b0, 32'h3FF, 32'h1234565A, 32'h0, 1'b0);
      txn("ld_half_top", 1'b0, 2'b01, 1'b1, 32'h3FF, 32'h0, 32'h0, 1'b1);
      txn("st_half_top", 1'b1, 2'b01, 1'b0, 32'h3FF, 32'h0000BBCC, 32'h0, 1'b1);
      txn("ld_byte_top", 1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0, 32'h0000005A, 1'b0);
      txn("ld_half_3fe", 1'b0, 2'b01, 1'b1, 32'h3FE, 32'h0, 32'h0000005A, 1'b0);
      txn("ld_word_3fd", 1'b0, 2'b10, 1'b0, 32'h3FD, 32'h0, 32'h0, 1'b1);
      txn("ld_big_addr", 1'b0, 2'b00, 1'b0, 32'h00010000, 32'h0, 32'h0, 1'b1);
      txn("ld_rsvd", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

      // Misaligned accesses.
      txn("st_byte_14", 1'b1, 2'b00, 1'b0, 32'h14, 32'h00000055, 32'h0, 1'b0);
`ifdef DATA_MEM_PORT_ALIGN_CHECK_EN
      txn("ld_word_11", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
      txn("ld_half_13", 1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 32'h0, 1'b1);
`else
      txn("ld_word_11", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'hADBEEF55, 1'b0);
      txn("ld_half_13", 1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 32'h0000EF55, 1'b0);
`endif

      // req_valid held high: accepts only every LAT cycles.
      @(negedge clk);
      req_valid    = 1'b1;
      req_write    = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b1;
      req_addr     = 32'h20;
      for (int i = 0; i < 3 * LAT; i++) begin
         chk($sformatf("b2b_ready_%0d", i), 32'(req_ready), 32'((i % LAT) == 0));
         chk($sformatf("b2b_valid_%0d", i), 32'(resp_valid), 32'(((i % LAT) == 0) && (i > 0)));
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("b2b_last_valid", 32'(resp_valid), 32'd1);
      chk("b2b_last_rdata", resp_rdata, 32'h00000080);
      $display("txn b2b three accepts spaced %0d cycles", LAT);

      // Reset while a load is in flight.
      @(negedge clk);
      send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      repeat (LAT / 2) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_valid", 32'(resp_valid), 32'd0);
      vcount = 0;
      for (int i = 0; i < 2 * LAT; i++) begin
         @(negedge clk);
         if (resp_valid) vcount++;
      end
      chk("mid_rst_no_resp", 32'(vcount), 32'd0);
      $display("txn reset_in_flight responses_seen=%0d", vcount);
      txn("ld_word_10_clr", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
      txn("ld_byte_top_clr", 1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0, 32'h0, 1'b0);

      // Stand-alone response wait used once more to confirm no stray pulse.
      send(1'b1, 2'b10, 1'b0, 32'h40, 32'h01020304);
      wait_resp("st_word_40", rd, er);
      chk("st_word_40_err", 32'(er), 32'd0);
      txn("ld_word_40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h01020304, 1'b0);
      txn("ld_half_42", 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'h00000304, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
